jk_monitor: RTL and testbench

Synthesizable response checker for the lab's `jk_ff` flip-flop, sitting on the observation side of a JK test fixture. It samples the `j`/`k` excitation and the DUT's `q` output on every rising clock edge. It runs a JK reference model and flags any cycle where `q` departs from the predicted next state. It counts checks and errors, and escalates to a sticky fault once an error limit is reached, so FPGA-board tests can report pass/fail without a simulator.

---
 rtl/jk_monitor.sv | 71 +++++++
 tb/tb_jk_monitor.sv | 113 +++++++++++
 2 files changed

// File: rtl/jk_monitor.sv
// jk_monitor: JK flip-flop response checker with saturating check/error counters and sticky fault.
module jk_monitor #(
  parameter int CNT_W = 16,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  output logic             exp_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             fault
);
  typedef enum logic [1:0] {IDLE, SEED, CHECK, FAULT} state_t;
  state_t state, state_d;
  logic exp_d, mis_d, nq;
  logic [CNT_W-1:0] err_d, chk_d, err_inc, chk_inc;
  // next state is built from the sampled DUT q so one bad edge yields one error
  assign nq = (j & ~q) | (~k & q);
  assign err_inc = &err_cnt ? err_cnt : err_cnt + 1'b1;
  assign chk_inc = &chk_cnt ? chk_cnt : chk_cnt + 1'b1;
  assign fault = state == FAULT;
  always_comb begin
    state_d = state;
    exp_d = exp_q;
    mis_d = 1'b0;
    err_d = err_cnt;
    chk_d = chk_cnt;
    if (!en) state_d = IDLE;
    else begin
      unique case (state)
        IDLE: begin
          err_d = '0;
          chk_d = '0;
          state_d = SEED;
        end
        SEED: begin
          exp_d = nq;
          state_d = CHECK;
        end
        CHECK: begin
          chk_d = chk_inc;
          mis_d = q != exp_q;
          err_d = mis_d ? err_inc : err_cnt;
          exp_d = nq;
          if (ERR_LIMIT != 0 && mis_d && 32'(err_d) == ERR_LIMIT) state_d = FAULT;
        end
        FAULT: state_d = FAULT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      exp_q <= 1'b0;
      mismatch <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
    end else begin
      state <= state_d;
      exp_q <= exp_d;
      mismatch <= mis_d;
      err_cnt <= err_d;
      chk_cnt <= chk_d;
    end
  end
endmodule

// File: tb/tb_jk_monitor.sv
// tb_jk_monitor: table-driven check of jk_monitor against a behavioural jk_ff with fault injection.
module tb_jk_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, j = 1'b0, k = 1'b0, flip = 1'b0, stuck = 1'b0;
  logic dq = 1'b0, q;
  logic exp_q, mismatch, fault;
  logic [15:0] err_cnt, chk_cnt;
  logic en_s = 1'b0;
  logic q_s = 1'b0;
  logic exp_q_s, mismatch_s, fault_s;
  logic [2:0] err_cnt_s, chk_cnt_s;
  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // reference jk_ff; flip upsets its stored state at an edge, stuck forces its output low
  always @(posedge clk) dq <= ((j & ~dq) | (~k & dq)) ^ flip;
  assign q = stuck ? 1'b0 : dq;

  jk_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .j(j), .k(k), .q(q),
    .exp_q(exp_q), .mismatch(mismatch), .err_cnt(err_cnt), .chk_cnt(chk_cnt), .fault(fault)
  );

  jk_monitor #(.CNT_W(3), .ERR_LIMIT(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .j(j), .k(k), .q(q_s),
    .exp_q(exp_q_s), .mismatch(mismatch_s), .err_cnt(err_cnt_s), .chk_cnt(chk_cnt_s), .fault(fault_s)
  );

  typedef struct {
    int en, j, k, flip, stuck;
    int e_exp, e_mis, e_err, e_chk, e_flt;
  } vec_t;
  vec_t v[23];

  task automatic check(input string name, input int got, input int want);
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e, input int m, input int er, input int c, input int f);
    n_vec++;
    check({tag, " exp_q"}, 32'(exp_q), e);
    check({tag, " mismatch"}, 32'(mismatch), m);
    check({tag, " err_cnt"}, 32'(err_cnt), er);
    check({tag, " chk_cnt"}, 32'(chk_cnt), c);
    check({tag, " fault"}, 32'(fault), f);
  endtask

  initial begin
    v = '{
      '{1,1,0,0,0, 0,0,0,0,0}, '{1,0,0,0,0, 1,0,0,0,0}, '{1,0,1,0,0, 0,0,0,1,0},
      '{1,0,0,0,0, 0,0,0,2,0}, '{1,1,1,0,0, 1,0,0,3,0}, '{1,1,1,0,0, 0,0,0,4,0},
      '{1,1,0,0,0, 1,0,0,5,0}, '{1,0,0,1,0, 1,0,0,6,0}, '{1,0,0,0,0, 0,1,1,7,0},
      '{1,0,0,0,0, 0,0,1,8,0}, '{1,1,1,0,0, 1,0,1,9,0}, '{1,1,1,0,0, 0,0,1,10,0},
      '{0,0,0,0,0, 0,0,1,10,0}, '{1,1,1,0,1, 0,0,0,0,0}, '{1,1,1,0,1, 1,0,0,0,0},
      '{1,1,1,0,1, 1,1,1,1,0}, '{1,1,1,0,1, 1,1,2,2,0}, '{1,1,1,0,1, 1,1,3,3,0},
      '{1,1,1,0,1, 1,1,4,4,1}, '{1,1,1,0,1, 1,0,4,4,1}, '{1,1,1,0,1, 1,0,4,4,1},
      '{0,1,1,0,1, 1,0,4,4,0}, '{1,0,0,0,0, 1,0,0,0,0}
    };
    #2 rst_n = 1'b0;
    #1 check_all("reset", 0, 0, 0, 0, 0);
    #9 rst_n = 1'b1;
    tick();
    check_all("idle", 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      en = v[i].en != 0;
      j = v[i].j != 0;
      k = v[i].k != 0;
      flip = v[i].flip != 0;
      stuck = v[i].stuck != 0;
      tick();
      check_all($sformatf("vec%0d", i), v[i].e_exp, v[i].e_mis, v[i].e_err, v[i].e_chk, v[i].e_flt);
    end
    flip = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1; j = 1'b1; k = 1'b1; stuck = 1'b1;
    repeat (4) tick();
    check_all("pre_rst", 1, 1, 2, 2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    check_all("rst_seed", 0, 0, 0, 0, 0);
    tick();
    check_all("rst_seeded", 1, 0, 0, 0, 0);
    tick();
    check_all("rst_check1", 1, 1, 1, 1, 0);
    en = 1'b0;
    tick();
    check_all("en_drop_err", 1, 0, 1, 1, 0);
    en_s = 1'b1; j = 1'b1; k = 1'b1;
    repeat (14) tick();
    n_vec++;
    check("sat chk_cnt", 32'(chk_cnt_s), 7);
    check("sat err_cnt", 32'(err_cnt_s), 7);
    check("sat fault", 32'(fault_s), 0);
    check("sat mismatch", 32'(mismatch_s), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
